// File: rtl/alu_share_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter_pkg
// Definitions shared by the ALU-sharing arbiter, its round-robin picker and
// the ALU itself.
//   - ALU command codes (also used by the core controller).
//   - FSM state encoding for the arbiter.
//   - Round-robin pointer advance helper.
// -----------------------------------------------------------------------------
package alu_share_arbiter_pkg;

    // ALU command codes. Any other command value makes the ALU return 0.
    localparam logic [3:0] A_COM_add = 4'd1;
    localparam logic [3:0] A_COM_sub = 4'd2;

    // Arbiter FSM: capture -> execute -> respond.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Next round-robin start position after granting requester g of n.
    function automatic int rr_next(input int g, input int n);
        return (g + 1) % n;
    endfunction

endpackage

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu
// Purely combinational add/sub ALU, modulo 2^DW (no carry/overflow).
// Ports:
//   a, b  [DW-1:0]  operands
//   cmd   [CW-1:0]  A_COM_add -> a+b, A_COM_sub -> a-b, anything else -> 0
//   y     [DW-1:0]  result
// -----------------------------------------------------------------------------
module alu
    import alu_share_arbiter_pkg::*;
#(
    parameter int DW = 32,
    parameter int CW = 4
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [CW-1:0] cmd,
    output logic [DW-1:0] y
);

    always_comb begin
        // NOTE: every combinational output gets a default before any branch;
        // a path that leaves it unassigned would infer a latch.
        y = '0;
        if (cmd == CW'(A_COM_add)) begin
            y = a + b;
        end else if (cmd == CW'(A_COM_sub)) begin
            y = a - b;
        end
    end

endmodule

// File: rtl/alu_rr_pick.sv
// -----------------------------------------------------------------------------
// alu_rr_pick
// Combinational round-robin picker. Returns the first set request bit found
// when searching ptr, ptr+1, ... wrapping modulo NREQ.
// Ports:
//   req  [NREQ-1:0]  request levels
//   ptr  [PW-1:0]    search start position (0..NREQ-1)
//   any              at least one request is set
//   g    [PW-1:0]    index of the selected requester (0 when any=0)
// -----------------------------------------------------------------------------
module alu_rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic            any,
    output logic [PW-1:0]   g
);

    logic [PW-1:0] idx;

    // Scan from the farthest offset back to ptr itself so that the final
    // assignment to g is the closest set bit at or after ptr.
    always_comb begin
        any = |req;
        g   = '0;
        idx = '0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            idx = PW'((int'(ptr) + off) % NREQ);
            if (req[idx]) begin
                g = idx;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
// Time-shares one combinational ALU between NREQ requesters. A round-robin
// pick in IDLE captures one requester's operands/command, the ALU runs from
// those registered copies in EXEC, the result is latched, and the requester
// gets a one-cycle done pulse. One operation per 3 cycles at most.
// Ports:
//   CLK, RST          clock (rising edge), asynchronous active-high reset
//   req    [NREQ]     request level per requester
//   a_in   [NREQ*DW]  operand A, requester i in [i*DW +: DW]
//   b_in   [NREQ*DW]  operand B, same slicing
//   cmd_in [NREQ*CW]  ALU command, requester i in [i*CW +: CW]
//   ack    [NREQ]     one-hot pulse: operands of requester i captured
//   done   [NREQ]     one-hot pulse: result valid for requester i
//   result [DW]       most recent result, held until the next done
//   busy              operation in flight (from capture through done cycle)
// -----------------------------------------------------------------------------
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = 32,
    parameter int CW   = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   a_in,
    input  logic [NREQ*DW-1:0]   b_in,
    input  logic [NREQ*CW-1:0]   cmd_in,
    output logic [NREQ-1:0]      ack,
    output logic [NREQ-1:0]      done,
    output logic [DW-1:0]        result,
    output logic                 busy
);

    localparam int PW = $clog2(NREQ);

    state_t          state;
    state_t          state_d;

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   g_q;
    logic [DW-1:0]   a_q;
    logic [DW-1:0]   b_q;
    logic [CW-1:0]   cmd_q;

    logic            pick_any;
    logic [PW-1:0]   pick_g;
    logic [DW-1:0]   alu_y;

    logic            capture;
    logic            latch_res;
    logic            advance_ptr;
    logic [NREQ-1:0] ack_d;
    logic [NREQ-1:0] done_d;
    logic            busy_d;

    alu_rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req  (req),
        .ptr  (ptr),
        .any  (pick_any),
        .g    (pick_g)
    );

    // The ALU only ever sees the captured copies, so requesters are free to
    // change their inputs once acked.
    alu #(
        .DW   (DW),
        .CW   (CW)
    ) u_alu (
        .a    (a_q),
        .b    (b_q),
        .cmd  (cmd_q),
        .y    (alu_y)
    );

    // ---------------------------------------------------------------------
    // FSM state register
    // ---------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values
            // regardless of statement order.
            state <= state_d;
        end
    end

    // ---------------------------------------------------------------------
    // Next state and registered-output next values
    // ---------------------------------------------------------------------
    always_comb begin
        state_d     = state;
        capture     = 1'b0;
        latch_res   = 1'b0;
        advance_ptr = 1'b0;
        ack_d       = '0;
        done_d      = '0;

        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    capture = 1'b1;
                    ack_d   = NREQ'(1) << pick_g;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                latch_res = 1'b1;
                state_d   = ST_RESP;
            end
            ST_RESP: begin
                // done is registered, so it shows during the cycle after
                // RESP, which is also the first cycle a new grant can occur
                // (ack and done therefore never overlap).
                advance_ptr = 1'b1;
                done_d      = NREQ'(1) << g_q;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Busy covers the whole operation including the result-return cycle.
        busy_d = (state_d != ST_IDLE) || (|done_d);
    end

    // ---------------------------------------------------------------------
    // Datapath and output registers
    // ---------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            // NOTE: operand/command/index registers are reset as well, so an
            // aborted operation leaves no stale values behind for the ALU.
            ptr    <= '0;
            g_q    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            cmd_q  <= '0;
            ack    <= '0;
            done   <= '0;
            busy   <= 1'b0;
            result <= '0;
        end else begin
            ack  <= ack_d;
            done <= done_d;
            busy <= busy_d;

            if (capture) begin
                g_q   <= pick_g;
                a_q   <= a_in[int'(pick_g) * DW +: DW];
                b_q   <= b_in[int'(pick_g) * DW +: DW];
                cmd_q <= cmd_in[int'(pick_g) * CW +: CW];
            end

            if (latch_res) begin
                result <= alu_y;
            end

            if (advance_ptr) begin
                ptr <= PW'(rr_next(int'(g_q), NREQ));
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arbiter
// Directed bench for alu_share_arbiter (NREQ=4, DW=32, CW=4).
// Outputs are sampled 1 time unit after each rising edge. Cycle naming:
// req seen at edge E0 -> ack after E0, done/result after E2, idle after E3.
// -----------------------------------------------------------------------------
module tb_alu_share_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 32;
    localparam int CW   = 4;

    logic                 CLK = 1'b0;
    logic                 RST = 1'b1;
    logic [NREQ-1:0]      req = '0;
    logic [NREQ*DW-1:0]   a_in = '0;
    logic [NREQ*DW-1:0]   b_in = '0;
    logic [NREQ*CW-1:0]   cmd_in = '0;
    logic [NREQ-1:0]      ack;
    logic [NREQ-1:0]      done;
    logic [DW-1:0]        result;
    logic                 busy;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    alu_share_arbiter #(
        .NREQ   (NREQ),
        .DW     (DW),
        .CW     (CW)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .req    (req),
        .a_in   (a_in),
        .b_in   (b_in),
        .cmd_in (cmd_in),
        .ack    (ack),
        .done   (done),
        .result (result),
        .busy   (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [CW-1:0] c);
        a_in[i*DW +: DW]   = a;
        b_in[i*DW +: DW]   = b;
        cmd_in[i*CW +: CW] = c;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ack"},  64'(ack),  64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
    endtask

    // Hard bound on run time.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] sim_exp [4];
        logic [DW-1:0] fair_exp;
        int            fair_g;

        // ---------------- reset state ----------------
        step();
        check_idle("rst");
        check("rst_result", 64'(result), 64'(0));
        RST = 1'b0;

        // ---------------- single add: 5 + 7 on requester 0 ----------------
        set_op(0, 32'd5, 32'd7, 4'd1);
        req = 4'b0001;
        step();
        check("add_ack",   64'(ack),  64'(4'b0001));
        check("add_busy1", 64'(busy), 64'(1));
        check("add_nodone", 64'(done), 64'(0));
        req = 4'b0000;
        step();
        check("add_ack_pulse", 64'(ack),  64'(0));
        check("add_busy2",     64'(busy), 64'(1));
        step();
        check("add_done",   64'(done),   64'(4'b0001));
        check("add_result", 64'(result), 64'(12));
        check("add_busy3",  64'(busy),   64'(1));
        check("add_ack3",   64'(ack),    64'(0));
        step();
        check_idle("add_end");
        check("add_hold", 64'(result), 64'(12));

        // ---------------- sub wrap: 0 - 1 on requester 2 ----------------
        set_op(2, 32'd0, 32'd1, 4'd2);
        req = 4'b0100;
        step();
        check("sub_ack", 64'(ack), 64'(4'b0100));
        req = 4'b0000;
        step();
        step();
        check("sub_done",   64'(done),   64'(4'b0100));
        check("sub_result", 64'(result), 64'(32'hFFFF_FFFF));
        step();
        check_idle("sub_end");

        // ---------------- reset to bring ptr back to 0 ----------------
        RST = 1'b1;
        #1;
        check("rst2_result", 64'(result), 64'(0));
        step();
        RST = 1'b0;

        // ---------------- simultaneous: all four requesting ----------------
        set_op(0, 32'd10,  32'd20, 4'd1);
        set_op(1, 32'd100, 32'd1,  4'd2);
        set_op(2, 32'd7,   32'd8,  4'd1);
        set_op(3, 32'd5,   32'd9,  4'd2);
        sim_exp[0] = 32'd30;
        sim_exp[1] = 32'd99;
        sim_exp[2] = 32'd15;
        sim_exp[3] = 32'hFFFF_FFFC;
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            step();
            check("sim_ack", 64'(ack), 64'(1) << k);
            req[k] = 1'b0;
            step();
            step();
            check("sim_done",   64'(done),   64'(1) << k);
            check("sim_result", 64'(result), 64'(sim_exp[k]));
        end
        step();
        check_idle("sim_end");

        // ---------------- fairness: req[0] and req[2] held ----------------
        set_op(0, 32'd1,  32'd2, 4'd1);
        set_op(2, 32'd50, 32'd8, 4'd2);
        req = 4'b0101;
        for (int k = 0; k < 8; k++) begin
            fair_g   = (k % 2 == 0) ? 0 : 2;
            fair_exp = (k % 2 == 0) ? 32'd3 : 32'd42;
            step();
            check("fair_ack", 64'(ack), 64'(1) << fair_g);
            step();
            step();
            check("fair_done",   64'(done),   64'(1) << fair_g);
            check("fair_result", 64'(result), 64'(fair_exp));
            if (k == 7) req = 4'b0000;
        end

        // ---------------- reset during EXEC ----------------
        set_op(1, 32'd9, 32'd9, 4'd1);
        req = 4'b0010;
        step();
        check("abort_ack",  64'(ack),  64'(4'b0010));
        check("abort_busy", 64'(busy), 64'(1));
        req = 4'b0000;
        #2;
        RST = 1'b1;
        #1;
        check_idle("abort_rst");
        check("abort_result", 64'(result), 64'(0));
        step();
        RST = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("abort_nodone", 64'(done), 64'(0));
        end
        // ptr must be 0 again: requester 1 wins over requester 3.
        set_op(3, 32'd77, 32'd1, 4'd1);
        req = 4'b1010;
        step();
        check("post_rst_ack", 64'(ack), 64'(4'b0010));
        req = 4'b0000;
        step();
        step();
        check("post_rst_done",   64'(done),   64'(4'b0010));
        check("post_rst_result", 64'(result), 64'(18));
        step();
        check_idle("post_rst_end");

        // ---------------- bad command, plus a withdrawn request ----------------
        set_op(0, 32'd3, 32'd4, 4'd7);
        req = 4'b0001;
        step();
        check("bad_ack", 64'(ack), 64'(4'b0001));
        req = 4'b1000;      // requester 3 asks during EXEC ...
        step();
        req = 4'b0000;      // ... and withdraws before the next IDLE
        step();
        check("bad_done",   64'(done),   64'(4'b0001));
        check("bad_result", 64'(result), 64'(0));
        step();
        check_idle("withdrawn");

        set_op(0, 32'd1, 32'd1, 4'd1);
        req = 4'b0001;
        step();
        check("add2_ack", 64'(ack), 64'(4'b0001));
        req = 4'b0000;
        step();
        step();
        check("add2_done",   64'(done),   64'(4'b0001));
        check("add2_result", 64'(result), 64'(2));
        step();
        check_idle("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
